// File: rtl/flash_bus_pkg.sv
// Shared definitions for the 6809 flash bus bridge: FSM encoding and bus constants.
package flash_bus_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam logic [7:0]  READ_FILL         = 8'hFF;
  localparam logic [15:0] DEFAULT_BASE_ADDR = 16'hE000;
endpackage

// File: rtl/flash_bus_bridge_sync_edge.sv
// Multi-stage synchronizer for an asynchronous bus clock with registered rise/fall strobes.
// Flops reset high so a line that is already high at reset exit produces no edge.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_sig,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);
  logic [STAGES-1:0] sync_q, sync_d;
  logic prev_q, prev_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], i_sig};
    prev_d = sync_q[STAGES-1];
    rise_d = sync_q[STAGES-1] & ~prev_q;
    fall_d = ~sync_q[STAGES-1] & prev_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q <= '1;
      prev_q <= 1'b1;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign o_sync = sync_q[STAGES-1];
  assign o_rise = rise_q;
  assign o_fall = fall_q;
endmodule

// File: rtl/flash_bus_bridge.sv
// Decodes 6809 accesses to the flash window into one req/ack/done transaction and stretches the CPU via o_MRDY
// (low 1 clk after Q-rise strobe, high 1 clk after i_done). Define MRDY_TIMEOUT_EN for the abort timer.
module flash_bus_bridge
  import flash_bus_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR      = DEFAULT_BASE_ADDR,
  parameter int          WINDOW_BITS    = 12,
  parameter int          SYNC_STAGES    = 2,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_E,
  input  logic                   i_Q,
  input  logic                   i_enable,
  input  logic [15:0]            i_ADDRESS_BUS,
  input  logic [7:0]             i_DataBus,
  input  logic                   i_RW,
  output logic                   o_req,
  output logic                   o_req_we,
  output logic [WINDOW_BITS-1:0] o_req_addr,
  output logic [7:0]             o_req_wdata,
  input  logic                   i_ack,
  input  logic                   i_done,
  input  logic [7:0]             i_rdata,
  output logic                   o_abort,
  output logic                   o_MRDY,
  output logic [7:0]             o_DataBus,
  output logic                   o_DataBus_oe,
  output logic                   o_err
);
  state_t state_q, state_d;
  logic req_q, req_d;
  logic we_q, we_d;
  logic [WINDOW_BITS-1:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic mrdy_q, mrdy_d;
  logic [7:0] dbus_q, dbus_d;
  logic err_q, err_d;
  logic abort_q, abort_d;

  logic e_sync, e_fall, q_rise;
  logic e_rise_unused, q_sync_unused, q_fall_unused;
  logic hit, accept, tmo_hit;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_e (
    .clk(clk), .reset(reset), .i_sig(i_E),
    .o_sync(e_sync), .o_rise(e_rise_unused), .o_fall(e_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_q (
    .clk(clk), .reset(reset), .i_sig(i_Q),
    .o_sync(q_sync_unused), .o_rise(q_rise), .o_fall(q_fall_unused)
  );

  assign hit    = (i_ADDRESS_BUS[15:WINDOW_BITS] == BASE_ADDR[15:WINDOW_BITS]);
  assign accept = (state_q == IDLE) && q_rise && hit && i_enable;

`ifdef MRDY_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic in_txn;

  assign in_txn  = (state_q == REQ) || (state_q == WAIT);
  assign tmo_hit = in_txn && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (accept)      cnt_d = '0;
    else if (in_txn) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
  assign tmo_hit    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mrdy_q  <= 1'b1;
      dbus_q  <= '0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mrdy_q  <= mrdy_d;
      dbus_q  <= dbus_d;
      err_q   <= err_d;
      abort_q <= abort_d;
    end
  end

  // A done arriving while still in REQ counts as ack+done and skips WAIT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = REQ;
      REQ:     if (i_done || tmo_hit) state_d = HOLD;
               else if (i_ack)        state_d = WAIT;
      WAIT:    if (i_done || tmo_hit) state_d = HOLD;
      HOLD:    if (e_fall) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mrdy_d       = mrdy_q;
    dbus_d       = dbus_q;
    err_d        = err_q;
    abort_d      = 1'b0;
    o_DataBus_oe = (state_q == HOLD) && !we_q && e_sync;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = i_ADDRESS_BUS[WINDOW_BITS-1:0];
          we_d    = ~i_RW;
          wdata_d = i_DataBus;
          mrdy_d  = 1'b0;
          req_d   = 1'b1;
          err_d   = 1'b0;
        end
      end
      REQ, WAIT: begin
        if (i_done) begin
          req_d  = 1'b0;
          mrdy_d = 1'b1;
          if (!we_q) dbus_d = i_rdata;
        end else if (tmo_hit) begin
          abort_d = 1'b1;
          req_d   = 1'b0;
          err_d   = 1'b1;
          mrdy_d  = 1'b1;
          if (!we_q) dbus_d = READ_FILL;
        end else if (i_ack) begin
          req_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign o_req       = req_q;
  assign o_req_we    = we_q;
  assign o_req_addr  = addr_q;
  assign o_req_wdata = wdata_q;
  assign o_abort     = abort_q;
  assign o_MRDY      = mrdy_q;
  assign o_DataBus   = dbus_q;
  assign o_err       = err_q;
endmodule

// File: tb/tb_flash_bus_bridge.sv
// Randomized scoreboard bench for flash_bus_bridge: a CPU bus model, a flash engine model with its own memory,
// and a monitor comparing requests, read data and MRDY timing against a window/memory reference model.
module tb_flash_bus_bridge;
`ifdef MRDY_TIMEOUT_EN
  localparam int TMO       = 16;
  localparam int DONE_LONG = 8;
`else
  localparam int TMO       = 1024;
  localparam int DONE_LONG = 40;
`endif
  localparam logic [33:0] RST_VEC = {1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};

  logic clk = 1'b0;
  logic reset, i_E, i_Q, i_enable, i_RW;
  logic [15:0] i_ADDRESS_BUS;
  logic [7:0] i_DataBus, i_rdata, o_req_wdata, o_DataBus;
  logic o_req, o_req_we, i_ack, i_done, o_abort, o_MRDY, o_DataBus_oe, o_err;
  logic [11:0] o_req_addr;

  int n_tests = 0, n_fail = 0, cyc = 0;
  int mon_req_cnt = 0, mon_mrdy_fall = 0, mon_abort_cnt = 0, req_cyc = 0;
  logic [20:0] exp_req[$];
  logic [7:0]  exp_rd[$];
  logic [7:0]  ref_mem[4096];
  logic [7:0]  eng_mem[4096];
  int eng_ack_dly = 0, eng_done_dly = 1, eng_mode = 0;
  bit eng_no_ack = 0;

  flash_bus_bridge #(
    .BASE_ADDR(16'hE000), .WINDOW_BITS(12), .SYNC_STAGES(2), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset), .i_E(i_E), .i_Q(i_Q), .i_enable(i_enable),
    .i_ADDRESS_BUS(i_ADDRESS_BUS), .i_DataBus(i_DataBus), .i_RW(i_RW),
    .o_req(o_req), .o_req_we(o_req_we), .o_req_addr(o_req_addr), .o_req_wdata(o_req_wdata),
    .i_ack(i_ack), .i_done(i_done), .i_rdata(i_rdata), .o_abort(o_abort), .o_MRDY(o_MRDY),
    .o_DataBus(o_DataBus), .o_DataBus_oe(o_DataBus_oe), .o_err(o_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [33:0] outs();
    return {o_req, o_req_we, o_req_addr, o_req_wdata, o_abort, o_MRDY, o_DataBus, o_DataBus_oe, o_err};
  endfunction

  task automatic set_eng(input int ack_dly, input int done_dly, input int mode);
    eng_ack_dly  = ack_dly;
    eng_done_dly = done_dly;
    eng_mode     = mode;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Flash engine model: owns its own memory, serves one request at a time.
  initial begin : engine
    logic [11:0] a;
    logic w;
    logic [7:0] wd, rd;
    i_ack = 1'b0; i_done = 1'b0; i_rdata = 8'h00;
    forever begin
      tick();
      if (o_req && !eng_no_ack) begin
        a = o_req_addr; w = o_req_we; wd = o_req_wdata;
        repeat (eng_ack_dly) tick();
        if (w) eng_mem[a] = wd;
        rd = eng_mem[a];
        if (eng_mode == 1) begin
          i_rdata = rd; i_ack = 1'b1; i_done = 1'b1;
          tick();
          i_ack = 1'b0; i_done = 1'b0;
        end else begin
          i_ack = 1'b1;
          tick();
          i_ack = 1'b0;
          repeat (eng_done_dly) tick();
          i_rdata = rd; i_done = 1'b1;
          tick();
          i_done = 1'b0;
        end
        i_rdata = 8'($urandom);
      end
    end
  end

  initial begin : monitor
    logic prev_req, prev_oe, prev_mrdy, inflight, done_seen;
    logic [20:0] e;
    prev_req = 1'b0; prev_oe = 1'b0; prev_mrdy = 1'b1; inflight = 1'b0; done_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        exp_req.delete();
        exp_rd.delete();
        prev_req = 1'b0; prev_oe = 1'b0; prev_mrdy = 1'b1; inflight = 1'b0; done_seen = 1'b0;
      end else begin
        if (done_seen) begin
          chk("mrdy_release_after_done", o_MRDY, 1'b1);
          done_seen = 1'b0;
        end
        if (o_req && !prev_req) begin
          mon_req_cnt++;
          req_cyc  = cyc;
          inflight = 1'b1;
          chk("req_expected", exp_req.size() != 0, 1'b1);
          if (exp_req.size() != 0) begin
            e = exp_req.pop_front();
            chk("req_fields", {o_req_we, o_req_addr, o_req_wdata}, e);
            chk("mrdy_low_with_req", o_MRDY, 1'b0);
          end
        end
        if (!o_MRDY && prev_mrdy) mon_mrdy_fall++;
        if (inflight && i_done) begin
          chk("mrdy_low_at_done", o_MRDY, 1'b0);
          inflight  = 1'b0;
          done_seen = 1'b1;
        end
        if (inflight && o_abort) begin
          mon_abort_cnt++;
          chk("abort_latency", cyc - req_cyc, TMO);
          chk("abort_err_mrdy_req", {o_err, o_MRDY, o_req}, 3'b110);
          inflight = 1'b0;
        end
        if (o_DataBus_oe && !prev_oe) begin
          chk("oe_expected", exp_rd.size() != 0, 1'b1);
          if (exp_rd.size() != 0) chk("read_data", o_DataBus, exp_rd.pop_front());
        end
        prev_req = o_req; prev_oe = o_DataBus_oe; prev_mrdy = o_MRDY;
      end
    end
  end

  // One 6809 bus cycle; the window/enable rule and memory contents form the reference model.
  task automatic cpu_cycle(input logic [15:0] a, input logic rw, input logic [7:0] d,
                           input logic en, input logic extra_q);
    logic hit;
    int c_req, c_fall, n;
    hit    = en && ((a >> 12) == (16'hE000 >> 12));
    c_req  = mon_req_cnt;
    c_fall = mon_mrdy_fall;
    i_ADDRESS_BUS = a; i_RW = rw; i_DataBus = d; i_enable = en;
    if (hit) begin
      exp_req.push_back({~rw, a[11:0], d});
      if (rw) exp_rd.push_back(eng_no_ack ? 8'hFF : ref_mem[a[11:0]]);
      else if (!eng_no_ack) ref_mem[a[11:0]] = d;
    end
    #23 i_Q = 1'b1;
    #25 i_E = 1'b1;
    #25 i_Q = 1'b0;
    if (extra_q) begin
      #25 i_Q = 1'b1;
      #25 i_Q = 1'b0;
    end
    n = 0;
    while (n < 4000) begin
      @(negedge clk);
      n++;
      if (o_MRDY) break;
    end
    if (n >= 4000) chk("mrdy_release_timeout", o_MRDY, 1'b1);
    #30 i_E = 1'b0;
    #45;
    chk("req_count", mon_req_cnt - c_req, hit);
    chk("mrdy_stretch_count", mon_mrdy_fall - c_fall, hit);
    chk("oe_off_after_e_fall", o_DataBus_oe, 1'b0);
    #($urandom_range(10, 40));
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not complete within time budget");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin : stim
    int c, n;
    bit ok;
    logic [15:0] a;
    logic rw, en;
    logic [7:0] d;
    reset = 1'b0; i_E = 1'b0; i_Q = 1'b0; i_enable = 1'b0;
    i_ADDRESS_BUS = 16'h0000; i_DataBus = 8'h00; i_RW = 1'b1;
    for (int i = 0; i < 4096; i++) begin
      ref_mem[i] = 8'($urandom);
      eng_mem[i] = ref_mem[i];
    end
    ref_mem[12'h123] = 8'h5A;
    eng_mem[12'h123] = 8'h5A;
    repeat (4) tick();
    chk("reset_values", outs(), RST_VEC);
    reset = 1'b1;
    repeat (3) tick();
    chk("idle_after_reset", outs(), RST_VEC);

    set_eng(3, DONE_LONG, 0);
    cpu_cycle(16'hE123, 1'b1, 8'h00, 1'b1, 1'b0);
    set_eng(1, 5, 0);
    cpu_cycle(16'hE010, 1'b0, 8'hA5, 1'b1, 1'b0);
    cpu_cycle(16'hE010, 1'b1, 8'h3C, 1'b1, 1'b0);
    cpu_cycle(16'hD000, 1'b1, 8'h00, 1'b1, 1'b0);
    cpu_cycle(16'hE000, 1'b1, 8'h00, 1'b0, 1'b0);
    set_eng(0, 2, 0);
    cpu_cycle(16'hE001, 1'b1, 8'h00, 1'b1, 1'b0);
    set_eng(2, DONE_LONG, 0);
    cpu_cycle(16'hE002, 1'b1, 8'h00, 1'b1, 1'b1);

`ifdef MRDY_TIMEOUT_EN
    eng_no_ack = 1'b1;
    cpu_cycle(16'hE200, 1'b1, 8'h00, 1'b1, 1'b0);
    eng_no_ack = 1'b0;
    chk("err_set_after_timeout", o_err, 1'b1);
    chk("abort_pulse_count", mon_abort_cnt, 1);
    set_eng(0, 1, 0);
    cpu_cycle(16'hE201, 1'b1, 8'h00, 1'b1, 1'b0);
    chk("err_cleared_by_access", o_err, 1'b0);
`endif

    // Reset while the engine holds the transaction in WAIT.
    set_eng(1, DONE_LONG, 0);
    c = mon_req_cnt;
    i_ADDRESS_BUS = 16'hE055; i_RW = 1'b1; i_DataBus = 8'h00; i_enable = 1'b1;
    exp_req.push_back({1'b0, 12'h055, 8'h00});
    exp_rd.push_back(ref_mem[12'h055]);
    #23 i_Q = 1'b1;
    #25 i_E = 1'b1;
    #25 i_Q = 1'b0;
    n = 0;
    while (n < 200 && !(mon_req_cnt != c && !o_req)) begin
      @(negedge clk);
      n++;
    end
    chk("reached_wait", mon_req_cnt - c, 1);
    chk("wait_mrdy_low", o_MRDY, 1'b0);
    tick();
    reset = 1'b0;
    tick();
    chk("reset_mid_wait", outs(), RST_VEC);
    reset = 1'b1;
    i_E = 1'b0;
    ok = 1'b1;
    repeat (DONE_LONG + 10) begin
      @(negedge clk);
      if (!o_MRDY || o_req || o_DataBus_oe || o_DataBus != 8'h00) ok = 1'b0;
    end
    chk("late_done_ignored", ok, 1'b1);
    set_eng(0, 3, 0);
    cpu_cycle(16'hE055, 1'b1, 8'h00, 1'b1, 1'b0);

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 9) < 7)
        a = {4'hE, ($urandom_range(0, 1) != 0) ? {8'h00, 4'($urandom)} : 12'($urandom)};
      else
        a = 16'($urandom);
      rw = 1'($urandom_range(0, 1));
      en = ($urandom_range(0, 9) != 0);
      d  = 8'($urandom);
      set_eng($urandom_range(0, 3), $urandom_range(0, 8), $urandom_range(0, 1));
      cpu_cycle(a, rw, d, en, $urandom_range(0, 4) == 0);
    end

    repeat (5) @(negedge clk);
    chk("queues_drained", exp_req.size() + exp_rd.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
